// File: rtl/vec_pkg.sv
// Shared types and sizes for the vector ALU pipeline.
// Opcode encodings and the S1 operand bundle live here.
package vec_pkg;

   localparam int LANES  = 4;
   localparam int LANE_W = 32;
   localparam int VEC_W  = LANES * LANE_W;

   typedef enum logic [2:0] {
      VROT32 = 3'd0,
      VXOR   = 3'd1,
      VADD32 = 3'd2,
      VSHR32 = 3'd3,
      VSHL32 = 3'd4
   } vec_op_e;

   typedef struct packed {
      logic [2:0]       op;
      logic [VEC_W-1:0] a;
      logic [VEC_W-1:0] b;
   } s1_data_t;

endpackage

// File: rtl/vec_alu_pipe_if.sv
// Issue and result handshakes of the vector ALU.
// master is the decode/writeback side, slave is the pipeline.
interface vec_alu_pipe_if #(
   parameter int TAG_W = 5
) ();
   import vec_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [VEC_W-1:0] in_a;
   logic [VEC_W-1:0] in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [VEC_W-1:0] out_result;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;

   modport master (
      output in_valid, in_op, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_illegal
   );

endinterface

// File: rtl/vec_lane_alu.sv
// One 32-bit lane of the vector ALU, purely combinational.
// Undefined opcodes yield zero and raise illegal.
module vec_lane_alu
   import vec_pkg::*;
(
   input  logic [2:0]        op,
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   output logic [LANE_W-1:0] y,
   output logic              illegal
);

   logic [4:0]          amt;
   logic [2*LANE_W-1:0] rot;

   assign amt = b[4:0];
   // Shifting a doubled copy leaves the rotate in the low half.
   assign rot = {a, a} >> amt;

   always_comb begin
      y       = '0;
      illegal = 1'b0;
      case (op)
         VROT32:  y = rot[LANE_W-1:0];
         VXOR:    y = a ^ b;
         VADD32:  y = a + b;
         VSHR32:  y = a >> amt;
         VSHL32:  y = a << amt;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/vec_alu_pipe.sv
// Two-stage 128-bit vector ALU: S1 holds operands, S2 the result.
// Both stages advance together so a full pipe streams one op per cycle.
module vec_alu_pipe
   import vec_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input logic           clk,
   input logic           rst_n,
   input logic           flush,
   vec_alu_pipe_if.slave bus
);

   s1_data_t         s1_d;
   logic             s1_valid;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_valid;
   logic [VEC_W-1:0] s2_result;
   logic [TAG_W-1:0] s2_tag;
   logic             s2_illegal;

   logic             s2_adv;
   logic             accept;
   logic             s1_move;
   logic [VEC_W-1:0] alu_y;
   logic [LANES-1:0] lane_ill;

   assign s2_adv       = !s2_valid || bus.out_ready;
   assign bus.in_ready = (!s1_valid || s2_adv) && !flush;
   assign accept       = bus.in_valid && bus.in_ready;
   assign s1_move      = s1_valid && s2_adv && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_d   <= '0;
         s1_tag <= '0;
      end else if (accept) begin
         s1_d   <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
         s1_tag <= bus.in_tag;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      vec_lane_alu u_lane (
         .op      (s1_d.op),
         .a       (s1_d.a[LANE_W*i +: LANE_W]),
         .b       (s1_d.b[LANE_W*i +: LANE_W]),
         .y       (alu_y[LANE_W*i +: LANE_W]),
         .illegal (lane_ill[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
      end else if (flush) begin
         s2_valid <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
      end
   end

   // Every lane decodes the same op, so the lane flags are identical.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_result  <= '0;
         s2_tag     <= '0;
         s2_illegal <= 1'b0;
      end else if (s1_move) begin
         s2_result  <= alu_y;
         s2_tag     <= s1_tag;
         s2_illegal <= lane_ill[0] | (|lane_ill[LANES-1:1] & 1'b0);
      end
   end

   assign bus.out_valid   = s2_valid;
   assign bus.out_result  = s2_result;
   assign bus.out_tag     = s2_tag;
   assign bus.out_illegal = s2_illegal;

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Self-checking bench for vec_alu_pipe with a lane-arithmetic reference model.
// Inputs change 2ns after a rising edge, outputs are sampled 1ns later.
module tb_vec_alu_pipe;
   import vec_pkg::*;

   localparam int TW = 5;

   typedef struct {
      logic [127:0]  res;
      logic [TW-1:0] tag;
      logic          ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   vec_alu_pipe_if #(.TAG_W(TW)) bus ();

   vec_alu_pipe #(.TAG_W(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] ref_res(input logic [2:0] op,
                                            input logic [127:0] a,
                                            input logic [127:0] b);
      logic [127:0] r;
      longint unsigned x, y, v, m;
      int unsigned s;
      r = '0;
      m = 64'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         x = 64'(a[32*i +: 32]);
         y = 64'(b[32*i +: 32]);
         s = 32'(b[32*i +: 5]);
         case (op)
            3'd0: v = ((x >> s) | (x << (32 - s))) & m;
            3'd1: v = x ^ y;
            3'd2: v = (x + y) % 64'h1_0000_0000;
            3'd3: v = x >> s;
            3'd4: v = (x << s) & m;
            default: v = 0;
         endcase
         r[32*i +: 32] = v[31:0];
      end
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.in_op     = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #13;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got v=%b i=%b exp 0 0",
                  bus.out_valid, bus.out_illegal);
      end
      checks++;
      if (bus.out_result !== 128'd0 || bus.out_tag !== 5'd0) begin
         errors++;
         $display("FAIL reset_data got %h/%h exp 0/0",
                  bus.out_result, bus.out_tag);
      end
      rst_n = 1'b1;
      tick();
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got rdy=%b v=%b exp 1 0",
                  bus.in_ready, bus.out_valid);
      end
      tick();
   endtask

   task automatic test_rot();
      bus.in_op    = VROT32;
      bus.in_a     = {4{32'h8000_0001}};
      bus.in_b     = {32'd33, 32'd31, 32'd0, 32'd1};
      bus.in_tag   = 5'd3;
      bus.in_valid = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rot_ready got %b exp 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rot_early got %b exp 0", bus.out_valid);
      end
      tick();
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd3) begin
         errors++;
         $display("FAIL rot_valid got v=%b t=%h exp 1 03",
                  bus.out_valid, bus.out_tag);
      end
      checks++;
      if (bus.out_result !== 128'hC0000000_00000003_80000001_C0000000) begin
         errors++;
         $display("FAIL rot_result got %h exp %h", bus.out_result,
                  128'hC0000000_00000003_80000001_C0000000);
      end
      tick();
   endtask

   task automatic test_add();
      bus.in_op    = VADD32;
      bus.in_a     = {4{32'hFFFF_FFFF}};
      bus.in_b     = 128'd1;
      bus.in_tag   = 5'd7;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 ||
          bus.out_result !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000) begin
         errors++;
         $display("FAIL add_result got v=%b %h exp 1 %h", bus.out_valid,
                  bus.out_result, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);
      end
      tick();
   endtask

   task automatic test_illegal();
      bus.in_op    = 3'd6;
      bus.in_a     = rnd128();
      bus.in_b     = rnd128();
      bus.in_tag   = 5'h1F;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 ||
          bus.out_tag !== 5'h1F) begin
         errors++;
         $display("FAIL illegal_flag got v=%b i=%b t=%h exp 1 1 1f",
                  bus.out_valid, bus.out_illegal, bus.out_tag);
      end
      checks++;
      if (bus.out_result !== 128'd0) begin
         errors++;
         $display("FAIL illegal_result got %h exp 0", bus.out_result);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [2:0]   ops[8];
      logic [127:0] as[8];
      logic [127:0] bs[8];
      int sent = 0;
      int got = 0;
      int first = -1;
      int last = -1;
      exp_t e;
      q.delete();
      for (int k = 0; k < 8; k++) begin
         ops[k] = 3'($urandom_range(0, 7));
         as[k]  = rnd128();
         bs[k]  = rnd128();
      end
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
         bus.in_valid = (sent < 8);
         if (sent < 8) begin
            bus.in_op  = ops[sent];
            bus.in_a   = as[sent];
            bus.in_b   = bs[sent];
            bus.in_tag = TW'(sent + 8);
         end
         #1;
         if (sent < 8) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_ready cyc %0d got %b exp 1",
                        cyc, bus.in_ready);
            end
         end
         if (bus.out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra got tag %h exp none", bus.out_tag);
            end else begin
               e = q.pop_front();
               if (bus.out_result !== e.res || bus.out_tag !== e.tag ||
                   bus.out_illegal !== e.ill) begin
                  errors++;
                  $display("FAIL b2b_out got %h/%h/%b exp %h/%h/%b",
                           bus.out_result, bus.out_tag, bus.out_illegal,
                           e.res, e.tag, e.ill);
               end
            end
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back('{ref_res(ops[sent], as[sent], bs[sent]),
                          TW'(sent + 8), ops[sent] > 3'd4});
            sent++;
         end
         tick();
      end
      bus.in_valid = 1'b0;
      checks++;
      if (got != 8 || last - first != 7) begin
         errors++;
         $display("FAIL b2b_stream got %0d outs over %0d cycles exp 8 over 8",
                  got, last - first + 1);
      end
   endtask

   task automatic test_backpressure();
      logic [2:0]   ops[3];
      logic [127:0] as[3];
      logic [127:0] bs[3];
      logic [127:0] snap_res;
      logic [TW-1:0] snap_tag;
      logic snap_ill;
      int sent = 0;
      int got = 0;
      exp_t e;
      q.delete();
      for (int k = 0; k < 3; k++) begin
         ops[k] = 3'($urandom_range(0, 4));
         as[k]  = rnd128();
         bs[k]  = rnd128();
      end
      for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
         bus.out_ready = (cyc >= 4);
         bus.in_valid  = (sent < 3);
         if (sent < 3) begin
            bus.in_op  = ops[sent];
            bus.in_a   = as[sent];
            bus.in_b   = bs[sent];
            bus.in_tag = TW'(sent + 20);
         end
         #1;
         if (cyc == 2 || cyc == 3) begin
            checks++;
            if (bus.in_ready !== 1'b0 || sent != 2) begin
               errors++;
               $display("FAIL bp_full cyc %0d got rdy=%b held=%0d exp 0 2",
                        cyc, bus.in_ready, sent);
            end
         end
         if (cyc == 2) begin
            snap_res = bus.out_result;
            snap_tag = bus.out_tag;
            snap_ill = bus.out_illegal;
         end
         if (cyc == 3) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== snap_res ||
                bus.out_tag !== snap_tag || bus.out_illegal !== snap_ill) begin
               errors++;
               $display("FAIL bp_stable got %b/%h/%h exp 1/%h/%h",
                        bus.out_valid, bus.out_result, bus.out_tag,
                        snap_res, snap_tag);
            end
         end
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra got tag %h exp none", bus.out_tag);
            end else begin
               e = q.pop_front();
               if (bus.out_result !== e.res || bus.out_tag !== e.tag) begin
                  errors++;
                  $display("FAIL bp_out got %h/%h exp %h/%h",
                           bus.out_result, bus.out_tag, e.res, e.tag);
               end
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back('{ref_res(ops[sent], as[sent], bs[sent]),
                          TW'(sent + 20), 1'b0});
            sent++;
         end
         tick();
      end
      bus.in_valid = 1'b0;
      #1;
      checks++;
      if (got != 3 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain got %0d outs, v=%b exp 3 outs, v=0",
                  got, bus.out_valid);
      end
      tick();
   endtask

   task automatic test_flush();
      logic [127:0] ca;
      logic [127:0] cb;
      ca = rnd128();
      cb = rnd128();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_op     = VXOR;
      bus.in_a      = rnd128();
      bus.in_b      = rnd128();
      bus.in_tag    = 5'd1;
      tick();
      bus.in_tag = 5'd2;
      tick();
      bus.in_op  = VSHL32;
      bus.in_a   = ca;
      bus.in_b   = cb;
      bus.in_tag = 5'd3;
      flush      = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_cycle got rdy=%b v=%b exp 0 1",
                  bus.in_ready, bus.out_valid);
      end
      tick();
      flush = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_after got v=%b rdy=%b exp 0 1",
                  bus.out_valid, bus.in_ready);
      end
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd3 ||
          bus.out_result !== ref_res(3'd4, ca, cb)) begin
         errors++;
         $display("FAIL flush_retry got %b/%h/%h exp 1/03/%h",
                  bus.out_valid, bus.out_tag, bus.out_result,
                  ref_res(3'd4, ca, cb));
      end
      tick();
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_leak got v=%b tag %h exp 0",
                  bus.out_valid, bus.out_tag);
      end
      tick();
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_op     = VADD32;
      bus.in_a      = rnd128();
      bus.in_b      = rnd128();
      bus.in_tag    = 5'd9;
      tick();
      bus.in_tag = 5'd10;
      tick();
      bus.in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_tag !== 5'd0 ||
          bus.out_result !== 128'd0) begin
         errors++;
         $display("FAIL rst_mid got v=%b t=%h r=%h exp 0 0 0",
                  bus.out_valid, bus.out_tag, bus.out_result);
      end
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         #1;
         if (bus.out_valid === 1'b1) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rst_ghost got %0d outputs exp 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_rot();
      test_add();
      test_illegal();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
